execute_stage_md: RTL and testbench
===================================

# execute_stage_md

Parametrised MIPS execute stage that sits between the ID/EX and EX/MEM pipeline registers. It keeps the forwarding muxes, ALU-source mux and destination-register mux of the current execute stage. On top of that it adds three things: an iterative multiply/divide unit with HI/LO registers, a stall handshake toward the hazard unit, and a registered EX/MEM output. Single-cycle ALU ops flow through with one cycle of latency. MULT/DIV run for WIDTH cycles in the background.

## Interface
- WIDTH, 32, datapath width (even, ≥8)
- REG_ADDR, 5, register-index width
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- valid_in  in  1  ID/EX holds a real instruction
- reg1, reg2  in  WIDTH  register-file operands
- imm  in  WIDTH  sign-extended immediate
- shamt  in  5  shift amount
- fwd_mem, fwd_wb  in  WIDTH  forwarded values from EX/MEM and MEM/WB
- ForwardAE, ForwardBE  in  2  00 reg, 01 fwd_mem, 10 fwd_wb, 11 reg
- aluSrc  in  1  1 selects imm as operand B
- regDst  in  1  0 selects rt_in, 1 selects rd_in
- rt_in, rd_in  in  REG_ADDR  destination candidates
- reg_write_in  in  1  instruction writes a GPR
- alu_ctrl  in  4  ALU op code
- md_op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO
- stall  out  1  ID/EX and earlier stages must hold
- md_busy  out  1  multiply/divide iteration in progress
- ex_valid, ex_reg_write  out  1  registered EX/MEM valid and write enable
- ex_result  out  WIDTH  registered ALU or HI/LO result
- ex_reg2  out  WIDTH  registered forwarded operand B, before the aluSrc mux; store data
- ex_dst  out  REG_ADDR  registered destination index

## Operation
- opA = mux(ForwardAE). fwdB = mux(ForwardBE). opB = aluSrc ? imm : fwdB.
- alu_ctrl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1000 SLTU, 1100 NOR
  - 1001 SLL, 1010 SRL, 1011 SRA: operate on opB by shamt
  - others → 0
- Arithmetic wraps modulo 2^WIDTH. No overflow trap.
- stall = valid_in & md_op≠000 & md_busy. Combinational.
- Every instruction that is not stalled is captured into EX/MEM.
- MULT/MULTU/DIV/DIVU:
  - Accepted when not stalled. opA and opB are latched into the unit and md_busy is set.
  - The instruction itself passes with ex_reg_write=0.
- MFHI/MFLO: ex_result = HI or LO, ex_reg_write = reg_write_in.
- Multiply: shift-add over operand magnitudes, 1 bit per cycle, producing a 2·WIDTH product. HI = upper half, LO = lower half.
- Divide: restoring, 1 quotient bit per cycle. LO = quotient (truncated toward zero), HI = remainder (sign of dividend).
- Signed variants take magnitudes at issue and apply the sign fix-up on the final edge.
- Divide by zero: LO = all ones, HI = dividend. No stall extension.
- Signed most-negative ÷ −1: LO = most-negative, HI = 0.
- Unit states: IDLE → RUN (counter 0..WIDTH−1) → IDLE. There is no separate done state.

## Timing
- Reset (async): ex_* = 0, HI = LO = 0, md_busy = 0, counter = 0, unit in IDLE. Reset during RUN aborts the operation. HI/LO read 0 afterwards.
- ALU latency: 1 edge from acceptance to ex_result.
- MD op accepted at edge E0. md_busy = 1 after E0. HI/LO are updated and md_busy = 0 after edge E0+WIDTH.
- While stall=1, EX/MEM captures a bubble: ex_valid = ex_reg_write = 0, other ex_* hold.
- MFHI presented in any cycle between E0 and E0+WIDTH stalls. It is accepted at the first edge with md_busy = 0 and returns the new HI.
- A second MD op presented while busy stalls the same way. It is accepted on the cycle md_busy reads 0; back-to-back issue has no dead cycle.
- valid_in = 0: bubble in EX/MEM, stall = 0, the MD unit keeps iterating.

## Test plan
- Reset pulse mid-RUN: all ex_* = 0, md_busy drops immediately; a subsequent MFLO returns 0.
- ADD with ForwardAE = 01, fwd_mem = 5, reg2 = 7: ex_result = 12 one edge later. SRA with opB = 0x80000000, shamt = 4 → 0xF8000000.
- MULT −3 × 7, then MFLO on the next cycle: stall high for 32 cycles, MFLO returns 0xFFFFFFEB, MFHI returns 0xFFFFFFFF.
- DIVU 100 / 7: LO = 14, HI = 2. DIV −7 / 2: LO = −3, HI = −1. DIV 0x80000000 / −1: LO = 0x80000000, HI = 0.
- DIVU 9 / 0: LO = 0xFFFFFFFF, HI = 9, completes in 32 cycles.
- MULTU issued, then an immediately following MULTU: the second stalls, then issues on the first cycle md_busy = 0; total 64 busy cycles, no gap between them.

Source files
------------

// File: rtl/execute_stage_md.sv
// MIPS execute stage: forwarding and ALU-source muxes, ALU, an iterative
// multiply/divide unit with HI/LO, a stall toward the hazard unit and a registered EX/MEM.
module execute_stage_md #(
   parameter int WIDTH    = 32,
   parameter int REG_ADDR = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_in,
   input  logic [WIDTH-1:0]    reg1,
   input  logic [WIDTH-1:0]    reg2,
   input  logic [WIDTH-1:0]    imm,
   input  logic [4:0]          shamt,
   input  logic [WIDTH-1:0]    fwd_mem,
   input  logic [WIDTH-1:0]    fwd_wb,
   input  logic [1:0]          ForwardAE,
   input  logic [1:0]          ForwardBE,
   input  logic                aluSrc,
   input  logic                regDst,
   input  logic [REG_ADDR-1:0] rt_in,
   input  logic [REG_ADDR-1:0] rd_in,
   input  logic                reg_write_in,
   input  logic [3:0]          alu_ctrl,
   input  logic [2:0]          md_op,
   output logic                stall,
   output logic                md_busy,
   output logic                ex_valid,
   output logic                ex_reg_write,
   output logic [WIDTH-1:0]    ex_result,
   output logic [WIDTH-1:0]    ex_reg2,
   output logic [REG_ADDR-1:0] ex_dst
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, RUN} mdState_t;

   mdState_t         mdState;
   logic [CW-1:0]    mdCount;
   logic [WIDTH-1:0] opA, fwdB, opB, aluOut;
   logic [WIDTH-1:0] acc, r1, r2, hiReg, loReg;
   logic             isMul, negHi, negLo, divZero;

   always_comb begin
      case (ForwardAE)
         2'b01:   opA = fwd_mem;
         2'b10:   opA = fwd_wb;
         default: opA = reg1;
      endcase
      case (ForwardBE)
         2'b01:   fwdB = fwd_mem;
         2'b10:   fwdB = fwd_wb;
         default: fwdB = reg2;
      endcase
   end

   assign opB = aluSrc ? imm : fwdB;

   always_comb begin
      aluOut = '0;
      case (alu_ctrl)
         4'b0000: aluOut = opA & opB;
         4'b0001: aluOut = opA | opB;
         4'b0010: aluOut = opA + opB;
         4'b0011: aluOut = opA ^ opB;
         4'b0110: aluOut = opA - opB;
         4'b0111: aluOut = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
         4'b1000: aluOut = {{(WIDTH-1){1'b0}}, opA < opB};
         4'b1100: aluOut = ~(opA | opB);
         4'b1001: aluOut = opB << shamt;
         4'b1010: aluOut = opB >> shamt;
         4'b1011: aluOut = $signed(opB) >>> shamt;
         default: aluOut = '0;
      endcase
   end

   logic mdArith, issueMul, opSigned, isMfhi, isMflo, accept, issue, signA, signB;
   logic [WIDTH-1:0] magA, magB;

   assign mdArith  = (md_op >= 3'b001) && (md_op <= 3'b100);
   assign issueMul = (md_op == 3'b001) || (md_op == 3'b010);
   assign opSigned = (md_op == 3'b001) || (md_op == 3'b011);
   assign isMfhi   = (md_op == 3'b101);
   assign isMflo   = (md_op == 3'b110);
   assign md_busy  = (mdState == RUN);
   assign stall    = valid_in & (md_op != 3'b000) & md_busy;
   assign accept   = valid_in & ~stall;
   assign issue    = accept & mdArith;
   assign signA    = opSigned & opA[WIDTH-1];
   assign signB    = opSigned & opB[WIDTH-1];
   assign magA     = signA ? -opA : opA;
   assign magB     = signB ? -opB : opB;

   // One iteration step: acc/r1 hold {partial product, multiplier} or {remainder, dividend}
   logic [WIDTH:0]     mulSum, divShift, divTrial;
   logic [WIDTH-1:0]   accN, r1N, hiFinal, loFinal;
   logic [2*WIDTH-1:0] prodFix;

   always_comb begin
      mulSum   = {1'b0, acc} + {1'b0, (r1[0] ? r2 : {WIDTH{1'b0}})};
      divShift = {acc, r1[WIDTH-1]};
      divTrial = divShift - {1'b0, r2};
      if (isMul) begin
         accN = mulSum[WIDTH:1];
         r1N  = {mulSum[0], r1[WIDTH-1:1]};
      end else begin
         accN = divTrial[WIDTH] ? divShift[WIDTH-1:0] : divTrial[WIDTH-1:0];
         r1N  = {r1[WIDTH-2:0], ~divTrial[WIDTH]};
      end
      prodFix = negLo ? -{accN, r1N} : {accN, r1N};
      if (isMul) begin
         hiFinal = prodFix[2*WIDTH-1:WIDTH];
         loFinal = prodFix[WIDTH-1:0];
      end else begin
         hiFinal = negHi ? -accN : accN;
         loFinal = divZero ? {WIDTH{1'b1}} : (negLo ? -r1N : r1N);
      end
   end

   // Multiply/divide sequencer: latch magnitudes at issue, iterate WIDTH steps, fix up signs on the last
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mdState <= IDLE;
         mdCount <= '0;
         acc     <= '0;
         r1      <= '0;
         r2      <= '0;
         hiReg   <= '0;
         loReg   <= '0;
         isMul   <= 1'b0;
         negHi   <= 1'b0;
         negLo   <= 1'b0;
         divZero <= 1'b0;
      end else begin
         case (mdState)
            IDLE: begin
               if (issue) begin
                  mdState <= RUN;
                  mdCount <= '0;
                  acc     <= '0;
                  isMul   <= issueMul;
                  r1      <= issueMul ? magB : magA;
                  r2      <= issueMul ? magA : magB;
                  negLo   <= signA ^ signB;
                  negHi   <= issueMul ? (signA ^ signB) : signA;
                  divZero <= ~issueMul & (opB == '0);
               end
            end
            RUN: begin
               acc     <= accN;
               r1      <= r1N;
               mdCount <= mdCount + 1'b1;
               if (mdCount == CW'(WIDTH-1)) begin
                  hiReg   <= hiFinal;
                  loReg   <= loFinal;
                  mdState <= IDLE;
                  mdCount <= '0;
               end
            end
            default: mdState <= IDLE;
         endcase
      end
   end

   // EX/MEM register: stalled or invalid cycles insert a bubble and hold the data fields
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_result    <= '0;
         ex_reg2      <= '0;
         ex_dst       <= '0;
      end else if (accept) begin
         ex_valid     <= 1'b1;
         ex_reg_write <= mdArith ? 1'b0 : reg_write_in;
         ex_result    <= isMfhi ? hiReg : (isMflo ? loReg : aluOut);
         ex_reg2      <= fwdB;
         ex_dst       <= regDst ? rd_in : rt_in;
      end else begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_stage_md.sv
// Directed bench for execute_stage_md: ALU paths, forwarding, MULT/DIV results,
// stall timing, back-to-back issue and reset abort.
module tb_execute_stage_md;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] reg1, reg2, imm, fwd_mem, fwd_wb;
   logic [4:0]  shamt;
   logic [1:0]  ForwardAE, ForwardBE;
   logic        aluSrc, regDst, reg_write_in;
   logic [4:0]  rt_in, rd_in;
   logic [3:0]  alu_ctrl;
   logic [2:0]  md_op;
   logic        stall, md_busy, ex_valid, ex_reg_write;
   logic [31:0] ex_result, ex_reg2;
   logic [4:0]  ex_dst;

   int compared   = 0;
   int mismatched = 0;
   int cnt;

   execute_stage_md #(.WIDTH(32), .REG_ADDR(5)) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .reg1(reg1), .reg2(reg2),
      .imm(imm), .shamt(shamt), .fwd_mem(fwd_mem), .fwd_wb(fwd_wb),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .aluSrc(aluSrc), .regDst(regDst),
      .rt_in(rt_in), .rd_in(rd_in), .reg_write_in(reg_write_in), .alu_ctrl(alu_ctrl),
      .md_op(md_op), .stall(stall), .md_busy(md_busy), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_result(ex_result), .ex_reg2(ex_reg2), .ex_dst(ex_dst)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction with neutral mux settings
   task automatic applyStimulus(input logic v, input logic [3:0] ctrl, input logic [2:0] mdop,
                                input logic [31:0] a, input logic [31:0] b);
      valid_in     = v;
      alu_ctrl     = ctrl;
      md_op        = mdop;
      reg1         = a;
      reg2         = b;
      imm          = 32'd0;
      shamt        = 5'd0;
      fwd_mem      = 32'd0;
      fwd_wb       = 32'd0;
      ForwardAE    = 2'b00;
      ForwardBE    = 2'b00;
      aluSrc       = 1'b0;
      regDst       = 1'b0;
      rt_in        = 5'd2;
      rd_in        = 5'd9;
      reg_write_in = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Issue one MD op, let it finish under bubbles, then read LO and HI back
   task automatic runMd(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expLo, input logic [31:0] expHi);
      int n;
      applyStimulus(1'b1, 4'b0000, op, a, b);
      step();
      checkOutput({tag, " busy"}, {31'd0, md_busy}, 32'd1);
      checkOutput({tag, " no write"}, {31'd0, ex_reg_write}, 32'd0);
      applyStimulus(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0);
      n = 0;
      for (int i = 0; i < 100 && md_busy; i++) begin
         n++;
         step();
      end
      checkOutput({tag, " cycles"}, n, 32'd32);
      applyStimulus(1'b1, 4'b0000, 3'b110, 32'd0, 32'd0);
      step();
      checkOutput({tag, " lo"}, ex_result, expLo);
      applyStimulus(1'b1, 4'b0000, 3'b101, 32'd0, 32'd0);
      step();
      checkOutput({tag, " hi"}, ex_result, expHi);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset ex_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("reset ex_result", ex_result, 32'd0);
      checkOutput("reset md_busy", {31'd0, md_busy}, 32'd0);
      reset = 1'b0;

      applyStimulus(1'b1, 4'b0010, 3'b000, 32'd99, 32'd7);
      ForwardAE = 2'b01;
      fwd_mem   = 32'd5;
      regDst    = 1'b1;
      rd_in     = 5'd3;
      step();
      checkOutput("add fwd_mem", ex_result, 32'd12);
      checkOutput("add dst", {27'd0, ex_dst}, 32'd3);
      checkOutput("add valid", {31'd0, ex_valid}, 32'd1);
      checkOutput("add write", {31'd0, ex_reg_write}, 32'd1);

      applyStimulus(1'b1, 4'b1011, 3'b000, 32'd0, 32'd0);
      aluSrc = 1'b1;
      imm    = 32'h8000_0000;
      shamt  = 5'd4;
      step();
      checkOutput("sra", ex_result, 32'hF800_0000);

      applyStimulus(1'b1, 4'b0010, 3'b000, 32'h100, 32'd1);
      aluSrc    = 1'b1;
      imm       = 32'd4;
      ForwardBE = 2'b10;
      fwd_wb    = 32'hABCD;
      step();
      checkOutput("addi result", ex_result, 32'h104);
      checkOutput("store data", ex_reg2, 32'hABCD);
      checkOutput("rt dst", {27'd0, ex_dst}, 32'd2);

      applyStimulus(1'b1, 4'b0110, 3'b000, 32'd5, 32'd7);
      step();
      checkOutput("sub wrap", ex_result, 32'hFFFF_FFFE);
      applyStimulus(1'b1, 4'b0111, 3'b000, 32'hFFFF_FFFF, 32'd1);
      step();
      checkOutput("slt signed", ex_result, 32'd1);
      applyStimulus(1'b1, 4'b1000, 3'b000, 32'hFFFF_FFFF, 32'd1);
      step();
      checkOutput("sltu", ex_result, 32'd0);
      applyStimulus(1'b1, 4'b1100, 3'b000, 32'h0F0F_0000, 32'h0000_00F0);
      step();
      checkOutput("nor", ex_result, 32'hF0F0_FF0F);
      applyStimulus(1'b1, 4'b1111, 3'b000, 32'd3, 32'd4);
      step();
      checkOutput("undefined op", ex_result, 32'd0);

      applyStimulus(1'b0, 4'b0010, 3'b000, 32'd1, 32'd1);
      step();
      checkOutput("bubble valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("bubble hold", ex_result, 32'd0);

      // MULT followed immediately by MFLO: the MFLO must wait out the whole iteration
      applyStimulus(1'b1, 4'b0000, 3'b001, 32'hFFFF_FFFD, 32'd7);
      step();
      checkOutput("mult no write", {31'd0, ex_reg_write}, 32'd0);
      applyStimulus(1'b1, 4'b0000, 3'b110, 32'd0, 32'd0);
      cnt = 0;
      for (int i = 0; i < 100 && stall; i++) begin
         cnt++;
         step();
         if (i == 0) checkOutput("stall bubble", {31'd0, ex_valid}, 32'd0);
      end
      checkOutput("mult stall cycles", cnt, 32'd32);
      step();
      checkOutput("mult lo", ex_result, 32'hFFFF_FFEB);
      checkOutput("mflo write", {31'd0, ex_reg_write}, 32'd1);
      applyStimulus(1'b1, 4'b0000, 3'b101, 32'd0, 32'd0);
      step();
      checkOutput("mult hi", ex_result, 32'hFFFF_FFFF);

      runMd("divu 100/7", 3'b100, 32'd100, 32'd7, 32'd14, 32'd2);
      runMd("div -7/2", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      runMd("div min/-1", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
      runMd("divu 9/0", 3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9);
      runMd("multu big", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'd1);

      // Back-to-back MULTU: second issues the first cycle md_busy reads 0
      applyStimulus(1'b1, 4'b0000, 3'b010, 32'd3, 32'd5);
      step();
      applyStimulus(1'b1, 4'b0000, 3'b010, 32'd6, 32'd7);
      cnt = 0;
      for (int i = 0; i < 100 && md_busy; i++) begin
         cnt++;
         step();
      end
      checkOutput("b2b stall released", {31'd0, stall}, 32'd0);
      step();
      checkOutput("b2b second busy", {31'd0, md_busy}, 32'd1);
      checkOutput("b2b second valid", {31'd0, ex_valid}, 32'd1);
      applyStimulus(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0);
      for (int i = 0; i < 100 && md_busy; i++) begin
         cnt++;
         step();
      end
      checkOutput("b2b busy total", cnt, 32'd64);
      applyStimulus(1'b1, 4'b0000, 3'b110, 32'd0, 32'd0);
      step();
      checkOutput("b2b lo", ex_result, 32'd42);

      // Reset in the middle of a run aborts it and clears HI/LO
      applyStimulus(1'b1, 4'b0000, 3'b010, 32'd5, 32'd6);
      step();
      applyStimulus(1'b0, 4'b0000, 3'b000, 32'd0, 32'd0);
      repeat (5) step();
      reset = 1'b1;
      #1;
      checkOutput("abort md_busy", {31'd0, md_busy}, 32'd0);
      checkOutput("abort ex_valid", {31'd0, ex_valid}, 32'd0);
      checkOutput("abort ex_result", ex_result, 32'd0);
      checkOutput("abort ex_reg2", ex_reg2, 32'd0);
      #1;
      reset = 1'b0;
      applyStimulus(1'b1, 4'b0000, 3'b110, 32'd0, 32'd0);
      step();
      checkOutput("abort mflo", ex_result, 32'd0);
      checkOutput("abort mflo valid", {31'd0, ex_valid}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
